mem_io_bridge: RTL and testbench
================================

// Module: mem_io_bridge
// PURPOSE
//  Sequential load/store bridge between CPU MEM stage, data memory and N_IO memory-mapped peripherals.
//  Decodes address to memory or IO channel; generates byte enables; aligns and extends read data.
//  Handles 1-cycle synchronous memory reads and variable-latency IO (ready handshake, timeout).
//  Drives cpu_stall while an access is outstanding. Sits between ALU result / register file and data-memory / IO blocks.
// PARAMETERS
//  DW         32            CPU data / address width (`ISA_WIDTH)
//  IO_W       16            peripheral data width
//  N_IO       4             number of IO channels (1..16)
//  IO_BASE    32'hFFFF_FC00 first IO address; addr >= IO_BASE is IO space
//  CH_SHIFT   4             log2 bytes per channel window (16 B)
//  IO_TMO     15            max wait cycles for io_ready before timeout (>=1)
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          asynchronous, active-high reset
//  cpu_rd      in   1          load request (level, held while cpu_stall)
//  cpu_wr      in   1          store request (level, held while cpu_stall)
//  cpu_addr    in   DW         byte address (ALU result)
//  cpu_wdata   in   DW         store data from register file
//  cpu_size    in   2          00 byte, 01 half, 10 word; 11 illegal
//  cpu_sext    in   1          1 = sign-extend byte/half loads
//  cpu_rdata   out  DW         load data to register write-back
//  cpu_stall   out  1          1 = hold pipeline, access pending
//  mem_en      out  1          memory access strobe
//  mem_be      out  DW/8       byte write enables (0 on read)
//  mem_addr    out  DW         word-aligned memory address
//  mem_wdata   out  DW         lane-replicated store data
//  mem_rdata   in   DW         memory read data, valid 1 cycle after mem_en
//  io_sel      out  N_IO       one-hot channel select, held during IO access
//  io_we       out  1          IO write strobe
//  io_wdata    out  IO_W       cpu_wdata[IO_W-1:0]
//  io_rdata    in   N_IO*IO_W  channel k at [k*IO_W +: IO_W]
//  io_ready    in   N_IO       per-channel completion
//  bus_err     out  1          sticky error flag
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; timeout counter 0; bus_err 0. Reset mid-access drops it, no retry.
//  FSM IDLE -> MEM_RD -> IDLE; IDLE -> IO_WAIT -> IO_DONE -> IDLE.
//  IDLE, no request: mem_en=0, io_sel=0, cpu_stall=0, cpu_rdata=0.
//  Error checks in IDLE, any error -> no access, stall 0, rdata 0, bus_err<=1, stay IDLE:
//   - misaligned: half with addr[0]=1, or word with addr[1:0]!=0
//   - cpu_size=11
//   - IO space with channel (addr-IO_BASE)>>CH_SHIFT >= N_IO
//  cpu_rd & cpu_wr both high: store performed, bus_err<=1.
//  Memory store: same cycle; mem_en=1, mem_be from size/addr[1:0]; no stall; stays IDLE.
//   mem_be: byte 1<<a[1:0]; half 0011<<(a[1]*2); word 1111.
//  Memory load: cycle N mem_en=1, be=0, cpu_stall=1, addr/size/sext latched -> MEM_RD.
//   In MEM_RD (N+1): cpu_rdata = extracted lanes, sign/zero-extended; stall=0; -> IDLE.
//  IO access: IDLE -> IO_WAIT; io_sel one-hot registered next cycle and held; io_we held for stores; stall=1.
//   Each IO_WAIT cycle: if io_ready[ch] capture io_rdata[ch] -> IO_DONE.
//   Otherwise count; on count==IO_TMO: bus_err<=1, data 0 -> IO_DONE.
//   IO_DONE: io_sel=0, stall=0, cpu_rdata = zero-extended IO_W data (0 for stores) -> IDLE.
//   io_ready on unselected channels ignored. Counter cleared on each IDLE exit.
//  Sizes on IO: byte/half loads extract from the IO_W word as for memory; stores always write full IO_W.
//  bus_err cleared only by rst. Request inputs sampled only in IDLE.
// STRUCTURE
//  definitions.v: size encodings, FSM state encodings, IO_BASE default, `ISA_WIDTH.
//  Sub-module lane_align (combinational): byte-enable generation, store replication, load extract/extend.
//  Top module holds FSM, latched request, timeout counter and output registers.
// TESTING
//  Reset mid-IO_WAIT: rst=1 -> io_sel=0, stall=0, bus_err=0 next edge; no spurious access after release.
//  sb 0xA5 @0x0000_0013 -> mem_en=1, mem_be=1000, mem_wdata=0xA5A5A5A5, stall=0.
//  lh sext @0x0000_0002, mem word 0x8001_1234 -> stall 1 cycle, cpu_rdata=0xFFFF_8001.
//  lw IO ch2 (0xFFFF_FC20), io_ready[2] after 3 cycles, data 0xBEEF -> io_sel=0100 for 3 cycles, then cpu_rdata=0x0000_BEEF.
//  lw IO ch1, io_ready never -> stall for IO_TMO+2=17 cycles total; cpu_rdata=0; bus_err=1 until reset.
//  lw @0x0000_0006 (misaligned) -> no mem_en, stall=0, rdata=0, bus_err=1.

Source files
------------

// File: rtl/mem_io_bridge_pkg.sv
// Shared encodings for the load/store bridge: access sizes, FSM states, IO window default.
// Also holds the alignment rule so decode and any future checker agree on it.
package mem_io_bridge_pkg;

    localparam int ISA_WIDTH = 32;
    localparam int OFF_W     = 2;

    localparam logic [31:0] IO_BASE_DFLT = 32'hFFFF_FC00;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_MEM_RD  = 2'b01;
    localparam logic [1:0] ST_IO_WAIT = 2'b10;
    localparam logic [1:0] ST_IO_DONE = 2'b11;

    typedef struct packed {
        logic             store;
        logic             sext;
        logic [1:0]       size;
        logic [OFF_W-1:0] off;
    } req_t;

    function automatic logic misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != '0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_io_bridge_lane_align.sv
// Byte-lane steering: store byte enables and replication, load lane extract with sign/zero extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides when the outputs are meaningful.
module mem_io_bridge_lane_align
    import mem_io_bridge_pkg::*;
#(
    parameter int DW = ISA_WIDTH
) (
    input  logic [1:0]       st_size,
    input  logic [OFF_W-1:0] st_off,
    input  logic [DW-1:0]    st_wdata,
    output logic [DW/8-1:0]  be,
    output logic [DW-1:0]    wdata_rep,
    input  logic [1:0]       ld_size,
    input  logic [OFF_W-1:0] ld_off,
    input  logic             ld_sext,
    input  logic [DW-1:0]    ld_word,
    output logic [DW-1:0]    ld_data
);

    localparam int NB = DW / 8;

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        case (st_size)
            SZ_BYTE: begin
                be        = {{(NB-1){1'b0}}, 1'b1} << st_off;
                wdata_rep = {NB{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = {{(NB-2){1'b0}}, 2'b11} << st_off;
                wdata_rep = {(NB/2){st_wdata[15:0]}};
            end
            SZ_WORD: begin
                be        = '1;
                wdata_rep = st_wdata;
            end
            default: begin
                be        = '0;
                wdata_rep = '0;
            end
        endcase
    end

    // Half loads are always halfword aligned, so only the upper offset bit picks the lane.
    assign ld_b = ld_word[{ld_off, 3'b000} +: 8];
    assign ld_h = ld_word[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            SZ_BYTE: ld_data = {{(DW-8){ld_sext & ld_b[7]}}, ld_b};
            SZ_HALF: ld_data = {{(DW-16){ld_sext & ld_h[15]}}, ld_h};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU load/store bridge to synchronous data memory and N_IO memory-mapped IO channels.
// Latency: mem store 0 cycles, mem load 1 cycle, IO 2..IO_TMO+2 cycles (ready or timeout).
// Backpressure: cpu_stall holds the pipeline while a load or IO access is outstanding.
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int              DW       = ISA_WIDTH,
    parameter int              IO_W     = 16,
    parameter int              N_IO     = 4,
    parameter logic [DW-1:0]   IO_BASE  = IO_BASE_DFLT,
    parameter int              CH_SHIFT = 4,
    parameter int              IO_TMO   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [DW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    input  logic [1:0]           cpu_size,
    input  logic                 cpu_sext,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_stall,
    output logic                 mem_en,
    output logic [DW/8-1:0]      mem_be,
    output logic [DW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic [N_IO-1:0]      io_sel,
    output logic                 io_we,
    output logic [IO_W-1:0]      io_wdata,
    input  logic [N_IO*IO_W-1:0] io_rdata,
    input  logic [N_IO-1:0]      io_ready,
    output logic                 bus_err
);

    localparam int CHW = (N_IO > 1) ? $clog2(N_IO) : 1;
    localparam int TW  = (IO_TMO > 1) ? $clog2(IO_TMO + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(IO_TMO);

    logic [1:0]      state;
    req_t            req_q;
    logic [CHW-1:0]  ch_q;
    logic [TW-1:0]   cnt;
    logic [IO_W-1:0] io_cap;

    logic            in_idle;
    logic            req;
    logic            is_io;
    logic [DW-1:0]   ch_full;
    logic [CHW-1:0]  ch;
    logic            ch_bad;
    logic            err;
    logic            go;
    logic            set_err;
    logic [N_IO-1:0] sel_dec;
    logic            io_hit;
    logic            io_fin;

    logic [DW/8-1:0] be_gen;
    logic [DW-1:0]   wdata_rep;
    logic [DW-1:0]   ld_word;
    logic [DW-1:0]   ld_data;

    // Requests are only looked at in IDLE; reset masks them so outputs stay quiet while held.
    assign in_idle = (state == ST_IDLE) && !rst;
    assign req     = cpu_rd | cpu_wr;
    assign is_io   = cpu_addr >= IO_BASE;
    assign ch_full = (cpu_addr - IO_BASE) >> CH_SHIFT;
    assign ch      = ch_full[CHW-1:0];
    assign ch_bad  = is_io && (ch_full >= DW'(N_IO));
    assign err     = misaligned(cpu_size, cpu_addr[OFF_W-1:0]) || (cpu_size == SZ_ILL) || ch_bad;
    assign go      = in_idle && req && !err;
    assign set_err = in_idle && req && (err || (cpu_rd && cpu_wr));

    always_comb begin
        sel_dec     = '0;
        sel_dec[ch] = 1'b1;
    end

    assign io_hit = io_ready[ch_q];
    assign io_fin = io_hit || (cnt == TMO_LAST);

    mem_io_bridge_lane_align #(.DW(DW)) u_lane (
        .st_size   (cpu_size),
        .st_off    (cpu_addr[OFF_W-1:0]),
        .st_wdata  (cpu_wdata),
        .be        (be_gen),
        .wdata_rep (wdata_rep),
        .ld_size   (req_q.size),
        .ld_off    (req_q.off),
        .ld_sext   (req_q.sext),
        .ld_word   (ld_word),
        .ld_data   (ld_data)
    );

    // IO data is zero-extended first, then goes through the same lane extract as memory.
    assign ld_word = (state == ST_MEM_RD) ? mem_rdata : {{(DW-IO_W){1'b0}}, io_cap};

    assign mem_en    = go && !is_io;
    assign mem_be    = (mem_en && cpu_wr) ? be_gen : '0;
    assign mem_addr  = mem_en ? {cpu_addr[DW-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wdata = (mem_en && cpu_wr) ? wdata_rep : '0;
    assign cpu_stall = (go && (is_io || !cpu_wr)) || (state == ST_IO_WAIT);
    assign cpu_rdata = ((state == ST_MEM_RD) || (state == ST_IO_DONE)) ? ld_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            req_q    <= '0;
            ch_q     <= '0;
            cnt      <= '0;
            io_sel   <= '0;
            io_we    <= 1'b0;
            io_wdata <= '0;
            io_cap   <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (set_err) begin
                bus_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        req_q.store <= cpu_wr;
                        req_q.sext  <= cpu_sext;
                        req_q.size  <= cpu_size;
                        req_q.off   <= cpu_addr[OFF_W-1:0];
                        cnt         <= '0;
                        if (is_io) begin
                            state    <= ST_IO_WAIT;
                            ch_q     <= ch;
                            io_sel   <= sel_dec;
                            io_we    <= cpu_wr;
                            io_wdata <= cpu_wdata[IO_W-1:0];
                        end else if (!cpu_wr) begin
                            state <= ST_MEM_RD;
                        end
                    end
                end
                ST_MEM_RD: begin
                    state <= ST_IDLE;
                end
                ST_IO_WAIT: begin
                    if (io_fin) begin
                        state    <= ST_IO_DONE;
                        io_sel   <= '0;
                        io_we    <= 1'b0;
                        io_wdata <= '0;
                        io_cap   <= (io_hit && !req_q.store) ? io_rdata[ch_q*IO_W +: IO_W] : '0;
                        if (!io_hit) begin
                            bus_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IO_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: memory stores/loads, IO ready/timeout, error cases, reset.
module tb_mem_io_bridge;
    import mem_io_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr, cpu_sext;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_size;
    logic        cpu_stall, mem_en;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  io_sel, io_ready;
    logic        io_we, bus_err;
    logic [15:0] io_wdata;
    logic [63:0] io_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_io_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_size  (cpu_size),
        .cpu_sext  (cpu_sext),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_en    (mem_en),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_sel    (io_sel),
        .io_we     (io_we),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ready  (io_ready),
        .bus_err   (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_size = SZ_BYTE; cpu_sext = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic mem_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd, input logic [3:0] ebe, input logic [31:0] ewd);
        tick;
        cpu_wr = 1'b1; cpu_addr = a; cpu_size = sz; cpu_wdata = wd;
        #1;
        chk({tag, " en"},    32'(mem_en), 32'h1);
        chk({tag, " be"},    32'(mem_be), 32'(ebe));
        chk({tag, " wdata"}, mem_wdata, ewd);
        chk({tag, " addr"},  mem_addr, a & 32'hFFFF_FFFC);
        chk({tag, " stall"}, 32'(cpu_stall), 32'h0);
        tick;
        idle_req;
    endtask

    task automatic mem_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic sx, input logic [31:0] word, input logic [31:0] exp);
        tick;
        cpu_rd = 1'b1; cpu_addr = a; cpu_size = sz; cpu_sext = sx;
        #1;
        chk({tag, " req stall"}, 32'(cpu_stall), 32'h1);
        chk({tag, " req en"},    32'(mem_en), 32'h1);
        chk({tag, " req be"},    32'(mem_be), 32'h0);
        tick;
        mem_rdata = word;
        #1;
        chk({tag, " rdata"},     cpu_rdata, exp);
        chk({tag, " rd stall"},  32'(cpu_stall), 32'h0);
        tick;
        idle_req;
        mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        idle_req;
        mem_rdata = '0; io_rdata = '0; io_ready = '0;
        tick; tick;
        chk("rst mem_en",  32'(mem_en), 32'h0);
        chk("rst stall",   32'(cpu_stall), 32'h0);
        chk("rst io_sel",  32'(io_sel), 32'h0);
        chk("rst bus_err", 32'(bus_err), 32'h0);
        chk("rst rdata",   cpu_rdata, 32'h0);
        rst = 1'b0;

        mem_store("sb", 32'h0000_0013, SZ_BYTE, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        mem_store("sh", 32'h0000_0022, SZ_HALF, 32'h1234_5678, 4'b1100, 32'h5678_5678);
        mem_store("sw", 32'h0000_0040, SZ_WORD, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        mem_load("lh",  32'h0000_0002, SZ_HALF, 1'b1, 32'h8001_1234, 32'hFFFF_8001);
        mem_load("lhu", 32'h0000_0002, SZ_HALF, 1'b0, 32'h8001_1234, 32'h0000_8001);
        mem_load("lb",  32'h0000_0003, SZ_BYTE, 1'b1, 32'h8001_1234, 32'hFFFF_FF80);
        mem_load("lbu", 32'h0000_0000, SZ_BYTE, 1'b0, 32'h8001_1234, 32'h0000_0034);
        mem_load("lw",  32'h0000_0004, SZ_WORD, 1'b1, 32'h1234_5678, 32'h1234_5678);

        // IO load ch2, ready on the third wait cycle; ch0 ready is noise.
        tick;
        cpu_rd = 1'b1; cpu_addr = 32'hFFFF_FC20; cpu_size = SZ_WORD;
        io_ready = 4'b0001;
        io_rdata = {16'h0000, 16'hBEEF, 16'h0000, 16'h1111};
        #1;
        chk("iord req stall", 32'(cpu_stall), 32'h1);
        chk("iord req mem_en", 32'(mem_en), 32'h0);
        chk("iord req sel", 32'(io_sel), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick;
            if (i == 2) io_ready = 4'b0100;
            #1;
            chk("iord wait sel", 32'(io_sel), 32'h4);
            chk("iord wait stall", 32'(cpu_stall), 32'h1);
        end
        tick;
        io_ready = '0;
        #1;
        chk("iord done sel", 32'(io_sel), 32'h0);
        chk("iord done stall", 32'(cpu_stall), 32'h0);
        chk("iord done rdata", cpu_rdata, 32'h0000_BEEF);
        chk("iord bus_err", 32'(bus_err), 32'h0);
        tick;
        idle_req;

        // IO byte store ch3 writes the full 16-bit word.
        tick;
        cpu_wr = 1'b1; cpu_addr = 32'hFFFF_FC31; cpu_size = SZ_BYTE; cpu_wdata = 32'h1234_ABCD;
        #1;
        chk("iowr req stall", 32'(cpu_stall), 32'h1);
        tick;
        io_ready = 4'b1000;
        #1;
        chk("iowr sel", 32'(io_sel), 32'h8);
        chk("iowr we", 32'(io_we), 32'h1);
        chk("iowr wdata", 32'(io_wdata), 32'h0000_ABCD);
        tick;
        io_ready = '0;
        #1;
        chk("iowr done stall", 32'(cpu_stall), 32'h0);
        chk("iowr done we", 32'(io_we), 32'h0);
        chk("iowr done rdata", cpu_rdata, 32'h0);
        tick;
        idle_req;

        // IO load ch1 never ready: timeout.
        tick;
        cpu_rd = 1'b1; cpu_addr = 32'hFFFF_FC10; cpu_size = SZ_WORD;
        io_ready = 4'b1101;
        #1;
        n = cpu_stall ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            #1;
            if (!cpu_stall) break;
            n++;
        end
        chk("tmo stall cycles", 32'(n), 32'd17);
        chk("tmo rdata", cpu_rdata, 32'h0);
        chk("tmo bus_err", 32'(bus_err), 32'h1);
        tick;
        idle_req;
        io_ready = '0;
        repeat (3) tick;
        chk("tmo bus_err sticky", 32'(bus_err), 32'h1);

        // Reset while waiting on IO ch0.
        tick;
        cpu_rd = 1'b1; cpu_addr = 32'hFFFF_FC00; cpu_size = SZ_WORD;
        tick;
        #1;
        chk("rstio wait sel", 32'(io_sel), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstio sel", 32'(io_sel), 32'h0);
        chk("rstio stall", 32'(cpu_stall), 32'h0);
        chk("rstio bus_err", 32'(bus_err), 32'h0);
        tick;
        rst = 1'b0;
        idle_req;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rstio quiet", {29'h0, mem_en, |io_sel, cpu_stall}, 32'h0);
        end

        // Channel beyond N_IO.
        tick;
        cpu_rd = 1'b1; cpu_addr = 32'hFFFF_FC40; cpu_size = SZ_WORD;
        #1;
        chk("badch stall", 32'(cpu_stall), 32'h0);
        chk("badch mem_en", 32'(mem_en), 32'h0);
        tick;
        idle_req;
        #1;
        chk("badch bus_err", 32'(bus_err), 32'h1);
        chk("badch io_sel", 32'(io_sel), 32'h0);
        do_reset;

        // Load and store together: store wins, error flagged.
        tick;
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h0000_0008;
        cpu_size = SZ_WORD; cpu_wdata = 32'h55AA_55AA;
        #1;
        chk("rdwr mem_en", 32'(mem_en), 32'h1);
        chk("rdwr be", 32'(mem_be), 32'hF);
        chk("rdwr stall", 32'(cpu_stall), 32'h0);
        tick;
        idle_req;
        #1;
        chk("rdwr bus_err", 32'(bus_err), 32'h1);
        do_reset;

        // Misaligned word load.
        tick;
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0006; cpu_size = SZ_WORD;
        #1;
        chk("mis mem_en", 32'(mem_en), 32'h0);
        chk("mis stall", 32'(cpu_stall), 32'h0);
        chk("mis rdata", cpu_rdata, 32'h0);
        tick;
        idle_req;
        #1;
        chk("mis bus_err", 32'(bus_err), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
